// File: rtl/riscv_fetch_queue_if.sv
// Fetch-queue bus bundle: IMEM request/response channel, redirect input and
// the F/D-stage handshake plus queue occupancy.
//   master : the fetch queue (drives imem_req/addr, fd_*, count)
//   slave  : the environment (IMEM, execute-stage redirect, decode stage)
interface riscv_fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
);
  logic                         imem_req;
  logic [XLEN-1:0]              imem_addr;
  logic                         imem_gnt;
  logic                         imem_rvalid;
  logic [31:0]                  imem_rdata;
  logic                         redirect;
  logic [XLEN-1:0]              redirect_pc;
  logic                         fd_valid;
  logic                         fd_ready;
  logic [31:0]                  fd_instr;
  logic [XLEN-1:0]              fd_pc;
  logic [XLEN-1:0]              fd_pcplus4;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport master (
    output imem_req, imem_addr, fd_valid, fd_instr, fd_pc, fd_pcplus4, count,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, fd_ready
  );
  modport slave (
    input  imem_req, imem_addr, fd_valid, fd_instr, fd_pc, fd_pcplus4, count,
    output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, fd_ready
  );
endinterface

// File: rtl/riscv_fetch_queue.sv
// Instruction-fetch front end: issues in-order word fetches to a req/gnt IMEM,
// buffers responses in a DEPTH-entry prefetch queue and presents
// {instr, pc, pc+4} to the F/D stage with valid/ready. A redirect flushes the
// queue and drops every response still in flight.
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active-high
//   bus  - riscv_fetch_queue_if.master (IMEM channel, redirect, F/D handshake, count)
// Optional feature: define RISCV_FETCH_BYPASS_EN to forward a response straight
// to fd_* when the queue is empty (0-cycle latency); default is fully queued.
module riscv_fetch_queue #(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input logic                 clk,
  input logic                 rst,
  riscv_fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  // In-flight counters carry headroom for stale responses piling up across
  // back-to-back redirects while IMEM is slow.
  localparam int OW = AW + 4;
  localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

  logic [XLEN-1:0] fetch_pc;
  logic [31:0]     q_instr [DEPTH];
  logic [XLEN-1:0] q_pc    [DEPTH];
  logic [XLEN-1:0] tag     [DEPTH];   // PC of each live request, in grant order
  logic [AW-1:0]   rd_ptr, wr_ptr, tag_rd, tag_wr;
  logic [CW-1:0]   count;
  logic [OW-1:0]   live, drop, live_nxt, drop_nxt;

  logic            flush, grant, stale_rsp, live_rsp, byp, pop, q_pop, push;
  logic            hd_valid;
  logic [31:0]     hd_instr;
  logic [XLEN-1:0] hd_pc;

  assign flush = rst | bus.redirect;

  // Only live requests reserve queue space; stale ones are dropped on arrival.
  assign bus.imem_req  = !flush && ((OW'(count) + live) < OW'(DEPTH));
  assign bus.imem_addr = fetch_pc;
  assign grant         = bus.imem_req & bus.imem_gnt;

  // Responses come back in order, so all stale ones precede any live one.
  assign stale_rsp = bus.imem_rvalid && (drop != '0);
  assign live_rsp  = bus.imem_rvalid && (drop == '0) && (live != '0);

`ifdef RISCV_FETCH_BYPASS_EN
  assign byp = live_rsp && (count == '0) && !flush;
`else
  assign byp = 1'b0;
`endif

  always_comb begin
    hd_valid = (count != '0);
    hd_instr = q_instr[rd_ptr];
    hd_pc    = q_pc[rd_ptr];
    if (byp) begin
      hd_valid = 1'b1;
      hd_instr = bus.imem_rdata;
      hd_pc    = tag[tag_rd];
    end
  end

  // Data is forced to zero when nothing is presented, so reset leaves fd_* at 0.
  assign bus.fd_valid   = hd_valid;
  assign bus.fd_instr   = hd_valid ? hd_instr : '0;
  assign bus.fd_pc      = hd_valid ? hd_pc : '0;
  assign bus.fd_pcplus4 = hd_valid ? hd_pc + XLEN'(4) : '0;
  assign bus.count      = count;

  assign pop   = hd_valid && bus.fd_ready && !flush;
  assign q_pop = pop && !byp;
  // A bypassed response taken by F/D this cycle never enters the queue.
  assign push  = live_rsp && !(byp && bus.fd_ready);

  assign live_nxt = live + OW'(grant) - OW'(live_rsp);
  assign drop_nxt = drop - OW'(stale_rsp);

  always_ff @(posedge clk) begin
    if (flush) begin
      fetch_pc <= rst ? (RESET_PC & WORD_MASK) : (bus.redirect_pc & WORD_MASK);
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
      count    <= '0;
      live     <= '0;
      // Everything still outstanding after this cycle's traffic becomes stale.
      drop     <= drop_nxt + live_nxt;
    end else begin
      if (grant) begin
        fetch_pc <= fetch_pc + XLEN'(4);
        tag_wr   <= tag_wr + AW'(1);
      end
      if (live_rsp) tag_rd <= tag_rd + AW'(1);
      if (push)     wr_ptr <= wr_ptr + AW'(1);
      if (q_pop)    rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(q_pop);
      live  <= live_nxt;
      drop  <= drop_nxt;
    end
  end

  // Storage needs no reset: every read is qualified by count/live.
  always_ff @(posedge clk) begin
    if (grant) tag[tag_wr] <= fetch_pc;
    if (push && !flush) begin
      q_instr[wr_ptr] <= bus.imem_rdata;
      q_pc[wr_ptr]    <= tag[tag_rd];
    end
  end
endmodule

// File: tb/tb_riscv_fetch_queue.sv
module tb_riscv_fetch_queue;
  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  riscv_fetch_queue_if #(.XLEN(XLEN), .DEPTH(DEPTH)) bus ();
  riscv_fetch_queue #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct { logic [31:0] addr; int due; } rsp_t;
  rsp_t pend[$];                     // IMEM: accepted requests awaiting response

  int n_chk = 0, n_fail = 0;
  int cyc = 0, last_due = 0, lat = 1, gnt_pct = 100, rdy_pct = 100;
  int n_pops, n_gnts, first_pop, c0, max_cnt;
  logic do_rst = 1'b1, do_redir = 1'b0;
  logic [31:0] redir_pc = '0;
  // Reference: program-order PC of the next instruction F/D should receive,
  // and of the next address IMEM should be asked for.
  logic [31:0] exp_fd_pc = RESET_PC, exp_gnt_pc = RESET_PC;
  logic stall_prev = 1'b0;
  logic [31:0] stall_addr = '0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs at negedge, sample 1ns later, update the model.
  task automatic step();
    int d;
    @(negedge clk);
    rst             = do_rst;
    bus.redirect    = do_redir;
    bus.redirect_pc = redir_pc;
    bus.imem_gnt    = ($urandom_range(99) < gnt_pct);
    bus.fd_ready    = ($urandom_range(99) < rdy_pct);
    bus.imem_rvalid = (pend.size() > 0) && (pend[0].due <= cyc);
    bus.imem_rdata  = bus.imem_rvalid ? word(pend[0].addr) : $urandom;
    #1;
    if (!do_rst && !do_redir && stall_prev) begin
      chk("req_hold", 32'(bus.imem_req), 32'd1);
      chk("addr_hold", bus.imem_addr, stall_addr);
    end
    chk("count_le_depth", 32'(bus.count <= DEPTH), 32'd1);
    if (bus.imem_req && bus.imem_gnt) begin
      chk("gnt_addr", bus.imem_addr, exp_gnt_pc);
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      pend.push_back('{addr: bus.imem_addr, due: d});
      exp_gnt_pc += 32'd4;
      n_gnts++;
    end
    if (bus.fd_valid && bus.fd_ready && !do_rst && !do_redir) begin
      chk("fd_pc", bus.fd_pc, exp_fd_pc);
      chk("fd_instr", bus.fd_instr, word(exp_fd_pc));
      chk("fd_pcplus4", bus.fd_pcplus4, exp_fd_pc + 32'd4);
      exp_fd_pc += 32'd4;
      n_pops++;
      if (first_pop < 0) first_pop = cyc;
    end
    stall_prev = bus.imem_req && !bus.imem_gnt;
    stall_addr = bus.imem_addr;
    if (bus.imem_rvalid) void'(pend.pop_front());
    if (do_rst) begin
      exp_fd_pc = RESET_PC; exp_gnt_pc = RESET_PC;
    end else if (do_redir) begin
      exp_fd_pc = redir_pc & ~32'd3; exp_gnt_pc = redir_pc & ~32'd3;
    end
    cyc++;
  endtask

  task automatic do_reset();
    do_rst = 1'b1; step(); step(); do_rst = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(bus.fd_valid), 32'd0);
    chk({tag, "_instr"}, bus.fd_instr, 32'd0);
    chk({tag, "_pc"}, bus.fd_pc, 32'd0);
    chk({tag, "_pcplus4"}, bus.fd_pcplus4, 32'd0);
    chk({tag, "_count"}, 32'(bus.count), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    bus.redirect = 1'b0; bus.redirect_pc = '0; bus.fd_ready = 1'b0;
    n_pops = 0; n_gnts = 0; first_pop = -1;

    // Reset state
    repeat (3) step();
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk_zero("rst");

    // T1 + T6: streaming at latency 1, first-instruction latency
    do_rst = 1'b0; c0 = cyc; n_pops = 0; first_pop = -1; max_cnt = 0;
    repeat (20) begin
      step();
      if (int'(bus.count) > max_cnt) max_cnt = int'(bus.count);
    end
`ifdef RISCV_FETCH_BYPASS_EN
    chk("t6_latency", 32'(first_pop - c0), 32'd1);
    chk("t1_pops", 32'(n_pops), 32'd19);
    chk("t6_count_max", 32'(max_cnt), 32'd0);
`else
    chk("t6_latency", 32'(first_pop - c0), 32'd2);
    chk("t1_pops", 32'(n_pops), 32'd18);
    chk("t6_count_max", 32'(max_cnt), 32'd1);
`endif

    // T2: F/D stalled -> exactly DEPTH grants, then drain in order
    do_reset();
    rdy_pct = 0; n_gnts = 0;
    repeat (10) step();
    chk("t2_grants", 32'(n_gnts), 32'd4);
    chk("t2_req", 32'(bus.imem_req), 32'd0);
    chk("t2_count", 32'(bus.count), 32'd4);
    chk("t2_head_pc", bus.fd_pc, 32'h0);
    rdy_pct = 100; n_pops = 0;
    repeat (8) step();
    chk("t2_drained", 32'(n_pops >= 4), 32'd1);
    chk("t2_resume", 32'(n_gnts >= 5), 32'd1);

    // T3: two in flight at latency 3, redirect to misaligned 0x102
    do_reset();
    lat = 3;
    step(); step();
    gnt_pct = 0; do_redir = 1'b1; redir_pc = 32'h102;
    step();
    do_redir = 1'b0; gnt_pct = 100;
    step();
    chk("t3_addr", bus.imem_addr, 32'h100);
    chk("t3_req", 32'(bus.imem_req), 32'd1);
    n_pops = 0;
    repeat (12) step();
    chk("t3_pops", 32'(n_pops > 0), 32'd1);

    // T4: redirect in the cycle IMEM would grant 0x8
    do_reset();
    lat = 1;
    step(); step();
    do_redir = 1'b1; redir_pc = 32'h40;
    step();
    chk("t4_addr", bus.imem_addr, 32'h8);
    chk("t4_req", 32'(bus.imem_req), 32'd0);
    do_redir = 1'b0;
    repeat (10) step();

    // T5: grant withheld, then reset mid-stream
    gnt_pct = 0;
    repeat (6) begin
      step();
      chk("t5_addr_const", bus.imem_addr, exp_gnt_pc);
    end
    chk("t5_drained", 32'(bus.fd_valid), 32'd0);
    gnt_pct = 100; rdy_pct = 0; lat = 2;
    repeat (6) step();
    do_rst = 1'b1; step(); do_rst = 1'b0;
    rdy_pct = 100;
    step();
    chk_zero("t5_post_rst");
    chk("t5_restart_addr", bus.imem_addr, RESET_PC);
    repeat (10) step();

    // Randomized traffic with redirects, resets and an address wrap
    gnt_pct = 70; rdy_pct = 70; n_pops = 0;
    for (int i = 0; i < 800; i++) begin
      lat = $urandom_range(1, 4);
      do_redir = 1'b0; do_rst = 1'b0;
      if (i == 400) begin
        do_redir = 1'b1; redir_pc = 32'hFFFF_FFF9;
      end else if (i < 380 || i > 440) begin
        do_redir = ($urandom_range(24) == 0);
        redir_pc = $urandom_range(32'hFFFF);
        do_rst   = ($urandom_range(199) == 0);
      end
      step();
    end
    do_redir = 1'b0; do_rst = 1'b0;
    chk("rand_pops", 32'(n_pops > 150), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
